// File: rtl/pitch_smoother.sv
// Moving-average pitch smoother: keeps the last DEPTH pitch bins, emits their
// truncated mean plus a stability flag whenever the full history advances.
module pitch_smoother #(
    parameter int W     = 10,
    parameter int DEPTH = 8,
    parameter int TOL   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [W-1:0]             pitch_in_data,
    input  logic                     pitch_in_valid,
    output logic                     pitch_in_ready,
    output logic [W-1:0]             pitch_out_data,
    output logic                     pitch_out_valid,
    input  logic                     pitch_out_ready,
    output logic                     pitch_stable,
    output logic [$clog2(DEPTH):0]   fill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = W + AW;
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {S_FILL, S_WAIT, S_SCAN, S_EMIT} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_buf [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_idx;
    logic [FW-1:0]  r_fill;
    logic [SW-1:0]  r_sum;
    logic [W-1:0]   r_min;
    logic [W-1:0]   r_max;
    logic [W-1:0]   r_out_data;
    logic           r_out_valid;
    logic           r_stable;
    logic           r_in_ready;
    logic           w_accept;
    logic           w_consume;
    logic [W-1:0]   w_entry;
    logic [W-1:0]   w_spread;

    // r_in_ready is only high in FILL/WAIT, so it alone qualifies an accept.
    assign w_accept  = pitch_in_valid && r_in_ready && !flush;
    assign w_consume = r_out_valid && pitch_out_ready;
    assign w_entry   = r_buf[r_idx];
    assign w_spread  = r_max - r_min;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FILL: if (w_accept && r_fill == FW'(DEPTH - 1)) w_next = S_SCAN;
            S_WAIT: if (w_accept) w_next = S_SCAN;
            S_SCAN: if (r_idx == AW'(DEPTH - 1)) w_next = S_EMIT;
            S_EMIT: if (w_consume) w_next = S_WAIT;
            default: w_next = S_FILL;
        endcase
        if (flush) w_next = S_FILL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FILL;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_wp] <= pitch_in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum       <= '0;
            r_wp        <= '0;
            r_idx       <= '0;
            r_fill      <= '0;
            r_min       <= '0;
            r_max       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_stable    <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            // Ready is registered from the next-state decode.
            r_in_ready <= (w_next == S_FILL) || (w_next == S_WAIT);
            if (flush) begin
                r_sum       <= '0;
                r_wp        <= '0;
                r_idx       <= '0;
                r_fill      <= '0;
                r_out_valid <= 1'b0;
                r_stable    <= 1'b0;
            end else begin
                case (r_state)
                    S_FILL: if (w_accept) begin
                        r_sum  <= r_sum + SW'(pitch_in_data);
                        r_wp   <= r_wp + AW'(1);
                        r_fill <= r_fill + FW'(1);
                    end
                    S_WAIT: if (w_accept) begin
                        r_sum <= r_sum + SW'(pitch_in_data) - SW'(r_buf[r_wp]);
                        r_wp  <= r_wp + AW'(1);
                    end
                    S_SCAN: begin
                        r_idx <= r_idx + AW'(1);
                        if (r_idx == '0) begin
                            r_min <= w_entry;
                            r_max <= w_entry;
                        end else begin
                            if (w_entry < r_min) r_min <= w_entry;
                            if (w_entry > r_max) r_max <= w_entry;
                        end
                    end
                    S_EMIT: begin
                        // First EMIT cycle latches the result; valid rises one cycle after SCAN ends.
                        if (!r_out_valid) begin
                            r_out_data  <= W'(r_sum >> AW);
                            r_stable    <= (w_spread <= W'(TOL));
                            r_out_valid <= 1'b1;
                        end else if (pitch_out_ready) begin
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pitch_in_ready  = r_in_ready;
    assign pitch_out_data  = r_out_data;
    assign pitch_out_valid = r_out_valid;
    assign pitch_stable    = r_stable;
    assign fill_count      = r_fill;

endmodule

// File: tb/tb_pitch_smoother.sv
// Bench for pitch_smoother (W=10, DEPTH=4, TOL=2): history-queue model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_pitch_smoother;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [9:0] pitch_in_data;
    logic       pitch_in_valid;
    logic       pitch_in_ready;
    logic [9:0] pitch_out_data;
    logic       pitch_out_valid;
    logic       pitch_out_ready;
    logic       pitch_stable;
    logic [2:0] fill_count;

    int checks = 0;
    int errors = 0;

    pitch_smoother #(.W(10), .DEPTH(4), .TOL(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .pitch_in_data   (pitch_in_data),
        .pitch_in_valid  (pitch_in_valid),
        .pitch_in_ready  (pitch_in_ready),
        .pitch_out_data  (pitch_out_data),
        .pitch_out_valid (pitch_out_valid),
        .pitch_out_ready (pitch_out_ready),
        .pitch_stable    (pitch_stable),
        .fill_count      (fill_count)
    );

    always #5 clk = ~clk;

    // Model: last four accepted samples; each accept that leaves four held
    // queues an expected output due six negedges later.
    int hist[$];
    int exp_d[$];
    int exp_s[$];
    int exp_t[$];
    bit busy = 1'b0;
    bit prev_valid = 1'b0;
    bit prev_cons = 1'b0;
    bit prev_flush = 1'b0;
    int ncyc = 0;

    always @(negedge clk) begin
        bit fl, acc, cons;
        int sum, mn, mx;
        ncyc++;
        if (!reset) begin
            hist.delete(); exp_d.delete(); exp_s.delete(); exp_t.delete();
            busy = 1'b0; prev_valid = 1'b0; prev_cons = 1'b0; prev_flush = 1'b0;
        end else begin
            checks++;
            if (pitch_in_ready !== !busy) begin
                errors++;
                $display("FAIL model_ready t=%0d got %0b expected %0b", ncyc, pitch_in_ready, !busy);
            end
            checks++;
            if (int'(fill_count) != hist.size()) begin
                errors++;
                $display("FAIL model_fill t=%0d got %0d expected %0d", ncyc, fill_count, hist.size());
            end
            if (pitch_out_valid === 1'b1) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL model_spurious t=%0d got valid=1 expected valid=0", ncyc);
                end else begin
                    if (int'(pitch_out_data) != exp_d[0] || int'(pitch_stable) != exp_s[0]) begin
                        errors++;
                        $display("FAIL model_out t=%0d got data=%0d stable=%0b expected data=%0d stable=%0d",
                                 ncyc, pitch_out_data, pitch_stable, exp_d[0], exp_s[0]);
                    end
                    if (!prev_valid && ncyc != exp_t[0]) begin
                        errors++;
                        $display("FAIL model_latency t=%0d got rise at %0d expected %0d", ncyc, ncyc, exp_t[0]);
                    end
                end
            end else begin
                if (prev_valid && !prev_cons && !prev_flush) begin
                    checks++; errors++;
                    $display("FAIL model_drop t=%0d got valid=0 expected valid=1", ncyc);
                end
                if (exp_t.size() != 0 && ncyc >= exp_t[0]) begin
                    checks++; errors++;
                    $display("FAIL model_late t=%0d got valid=0 expected valid=1 from %0d", ncyc, exp_t[0]);
                end
            end
            fl   = flush;
            acc  = pitch_in_valid && pitch_in_ready && !fl;
            cons = pitch_out_valid && pitch_out_ready && !fl;
            if (fl) begin
                hist.delete(); exp_d.delete(); exp_s.delete(); exp_t.delete();
                busy = 1'b0;
            end else begin
                if (cons && exp_d.size() != 0) begin
                    void'(exp_d.pop_front()); void'(exp_s.pop_front()); void'(exp_t.pop_front());
                    busy = 1'b0;
                end
                if (acc) begin
                    hist.push_back(int'(pitch_in_data));
                    if (hist.size() > 4) void'(hist.pop_front());
                    if (hist.size() == 4) begin
                        sum = 0; mn = hist[0]; mx = hist[0];
                        foreach (hist[i]) begin
                            sum += hist[i];
                            if (hist[i] < mn) mn = hist[i];
                            if (hist[i] > mx) mx = hist[i];
                        end
                        exp_d.push_back(sum / 4);
                        exp_s.push_back((mx - mn) <= 2 ? 1 : 0);
                        exp_t.push_back(ncyc + 6);
                        busy = 1'b1;
                    end
                end
            end
            prev_valid = pitch_out_valid;
            prev_cons  = cons;
            prev_flush = fl;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int x);
        bit acc = 1'b0;
        pitch_in_valid = 1'b1;
        pitch_in_data  = 10'(x);
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = pitch_in_ready;
            @(posedge clk);
            #1;
        end
        pitch_in_valid = 1'b0;
        chk("send_accepted", int'(acc), 1);
    endtask

    task automatic wait_out(output int n, output int d, output int s);
        bit found = 1'b0;
        n = 0; d = -1; s = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n = k + 1;
            if (pitch_out_valid) begin
                d = int'(pitch_out_data);
                s = int'(pitch_stable);
                found = 1'b1;
                break;
            end
        end
        chk("out_seen", int'(found), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_no_out(input string name, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (pitch_out_valid) seen++;
        end
        chk(name, seen, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush(input bit with_sample, input int x);
        flush = 1'b1;
        pitch_in_valid = with_sample;
        pitch_in_data  = 10'(x);
        @(posedge clk);
        #1;
        flush = 1'b0;
        pitch_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, s, low, bad;
        bit got;
        reset = 1'b0; flush = 1'b0; pitch_in_valid = 1'b0; pitch_in_data = '0;
        pitch_out_ready = 1'b1;
        #12;
        chk("rst_ready", int'(pitch_in_ready), 0);
        chk("rst_valid", int'(pitch_out_valid), 0);
        chk("rst_data", int'(pitch_out_data), 0);
        chk("rst_stable", int'(pitch_stable), 0);
        chk("rst_fill", int'(fill_count), 0);
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(pitch_in_ready), 1);

        // First full history: 403 >> 2 = 100, spread 2 is stable.
        send(100); send(100); send(101); send(102);
        wait_out(n, d, s);
        chk("first_latency", n - 1, 5);
        chk("first_data", d, 100);
        chk("first_stable", s, 1);
        chk("first_fill", int'(fill_count), 4);

        // 100,101,102,110: sum 413 -> 103, spread 10.
        send(110);
        low = 0; got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (pitch_out_valid && !got) begin
                got = 1'b1;
                chk("second_data", int'(pitch_out_data), 103);
                chk("second_stable", int'(pitch_stable), 0);
            end
            if (pitch_in_ready) break;
            low++;
        end
        chk("second_ready_low", low, 6);
        @(posedge clk); #1;

        // Backpressure: 101,102,110,105 -> 104; upstream offers 107 meanwhile.
        pitch_out_ready = 1'b0;
        send(105);
        wait_out(n, d, s);
        chk("hold_data", d, 104);
        chk("hold_stable_flag", s, 0);
        pitch_in_valid = 1'b1; pitch_in_data = 10'd107;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!pitch_out_valid || pitch_out_data != 10'd104 || pitch_stable || pitch_in_ready) bad++;
        end
        chk("hold_unchanged", bad, 0);
        @(posedge clk); #1;
        pitch_out_ready = 1'b1;
        send(107);
        wait_out(n, d, s);
        chk("after_hold_data", d, 106);
        chk("after_hold_stable", s, 0);

        // Flush drops a same-cycle sample and restarts the fill.
        pulse_flush(1'b0, 0);
        send(50); send(60); send(70);
        chk("pre_flush_fill", int'(fill_count), 3);
        pulse_flush(1'b1, 999);
        chk("post_flush_fill", int'(fill_count), 0);
        chk("post_flush_ready", int'(pitch_in_ready), 1);
        send(20); send(21); send(22);
        idle_no_out("flush_no_early_out", 10);
        chk("flush_fill3", int'(fill_count), 3);
        send(23);
        wait_out(n, d, s);
        chk("flush_data", d, 21);
        chk("flush_stable_tol_plus1", s, 0);

        // Reset during SCAN abandons the pending output.
        send(30);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_ready", int'(pitch_in_ready), 0);
        chk("midrst_valid", int'(pitch_out_valid), 0);
        chk("midrst_data", int'(pitch_out_data), 0);
        chk("midrst_stable", int'(pitch_stable), 0);
        chk("midrst_fill", int'(fill_count), 0);
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        send(40); send(41); send(42);
        idle_no_out("reset_no_early_out", 10);
        send(41);
        wait_out(n, d, s);
        chk("reset_data", d, 41);
        chk("reset_stable_tol_exact", s, 1);

        // Full-scale samples across three pointer wraps.
        pulse_flush(1'b0, 0);
        for (int i = 0; i < 12; i++) send(1023);
        wait_out(n, d, s);
        chk("max_data", d, 1023);
        chk("max_stable", s, 1);
        chk("max_fill", int'(fill_count), 4);
        repeat (5) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pitch_smoother.md
PITCH_SMOOTHER -- requirements
Module: pitch_smoother

Interface
REQ-001 Parameter W, default 10: pitch bin width in bits, range 4..16.
REQ-002 Parameter DEPTH, default 8: history length in samples; power of two, range 2..64.
REQ-003 Parameter TOL, default 2: maximum max-min spread, in bins, that still counts as stable.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset; asserted when low.
REQ-006 flush  input  1: synchronous clear of history; single-cycle pulse.
REQ-007 pitch_in_data  input  W: pitch bin from the FFT peak detector.
REQ-008 pitch_in_valid  input  1: pitch_in_data is valid.
REQ-009 pitch_in_ready  output  1: block accepts a sample this cycle.
REQ-010 pitch_out_data  output  W: moving-average pitch bin.
REQ-011 pitch_out_valid  output  1: pitch_out_data and pitch_stable are valid.
REQ-012 pitch_out_ready  input  1: downstream accepts the output.
REQ-013 pitch_stable  output  1: high when history spread is <= TOL.
REQ-014 fill_count  output  clog2(DEPTH)+1: number of samples held, 0..DEPTH.

Function
REQ-015 History: circular buffer of DEPTH W-bit entries with write pointer wp; wp wraps from DEPTH-1 to 0.
REQ-016 Handshake: a sample is accepted when pitch_in_valid && pitch_in_ready; an output is consumed when pitch_out_valid && pitch_out_ready.
REQ-017 FSM states: FILL, WAIT, SCAN, EMIT.
REQ-018 FILL: pitch_in_ready=1; each accept writes buf[wp], increments wp and fill_count, and adds the sample to sum.
- When fill_count reaches DEPTH, go to SCAN in the next cycle.
REQ-019 WAIT (buffer full): pitch_in_ready=1; on accept:
- sum <= sum + new - buf[wp]
- buf[wp] <= new
- wp increments
- go to SCAN
REQ-020 SCAN: pitch_in_ready=0; iterate index 0..DEPTH-1, one entry per cycle, tracking running min and max; exactly DEPTH cycles, then go to EMIT.
REQ-021 EMIT entry actions:
- pitch_out_data = sum >> log2(DEPTH) (truncating)
- pitch_stable = (max - min) <= TOL (unsigned compare)
- pitch_out_valid = 1
REQ-022 EMIT: pitch_in_ready=0; outputs held stable until consumed; on consume, clear pitch_out_valid and go to WAIT.
REQ-023 Latency: accept of the DEPTH-th (or later) sample to pitch_out_valid high is DEPTH+1 cycles.
REQ-024 No output is produced while fill_count < DEPTH.
REQ-025 sum width is W+log2(DEPTH); sum never overflows; the subtract-then-add in WAIT is exact.
REQ-026 pitch_in_ready is a registered-state decode only; it has no combinational path from pitch_out_ready.
REQ-027 flush in any state:
- returns to FILL next cycle
- clears sum, wp, fill_count, pitch_out_valid and pitch_stable
- drops any sample offered in the same cycle
- flush has priority over accept and consume.
REQ-028 pitch_out_valid, once high, does not drop without a consume, except on flush or reset.

Reset
REQ-029 While reset is low, the block is asynchronously forced to:
- state FILL
- sum=0, wp=0, fill_count=0
- pitch_out_valid=0, pitch_out_data=0, pitch_stable=0
- pitch_in_ready=0
REQ-030 The first cycle after reset is released has pitch_in_ready=1; buffer contents need no reset.
REQ-031 Reset asserted mid-SCAN or mid-EMIT abandons the pending output; no pitch_out_valid pulse follows release.

Verification (bench DEPTH=4, TOL=2, W=10)
REQ-032 Feed 100,100,101,102, pitch_out_ready=1 -> pitch_out_valid 5 cycles after 4th accept; data=100 (403>>2); stable=1; fill_count=4.
REQ-033 Then feed 110 -> sum=413, data=103, stable=0 (spread 10); pitch_in_ready low for exactly 6 cycles (SCAN 4 + EMIT 1 + return).
REQ-034 Hold pitch_out_ready=0 for 20 cycles in EMIT -> data/valid/stable unchanged, pitch_in_ready=0 throughout, no sample lost upstream.
REQ-035 Feed 3 samples, pulse flush with a valid sample in the same cycle -> fill_count=0, that sample not stored, 4 further samples needed before any output.
REQ-036 Assert reset low during SCAN -> all outputs zero immediately (asynchronously); after release, no output until 4 new samples.
REQ-037 Feed 12 samples of 1023 -> wp wraps 3 times, sum=4092, data=1023, stable=1, no overflow.
